// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared types and defaults for the fetch/decode pipeline registers
package cpu_pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
  localparam int PC_W_DEF = 12;
  localparam int INST_W_DEF = 16;
  localparam int FWD_W_DEF = 4;
  localparam logic [INST_W_DEF-1:0] NOP_INST_DEF = '0;
  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
    logic [FWD_W_DEF-1:0]  fwd;
  } payload_t;
endpackage

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: single-entry payload register with clear-over-load priority
module pipe_payload_reg
  import cpu_pipe_pkg::*;
#(
  parameter type T = payload_t,
  parameter T CLR_VAL = T'('0)
) (
  input  logic clk,
  input  logic clr,
  input  logic ld,
  input  T     d,
  output T     q
);
  // clear wins so a squash always leaves the NOP payload behind
  always_ff @(posedge clk)
    if (clr) q <= CLR_VAL;
    else if (ld) q <= d;
endmodule

// File: rtl/decode_stage_reg.sv
// decode_stage_reg: fetch-to-decode register with two-entry skid buffer, flush and stall counter
module decode_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int FWD_LSB = 4,
  parameter int FWD_W = FWD_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF),
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_f,
  output logic               ready_f,
  input  logic [PC_W-1:0]    pc_f,
  input  logic [INST_W-1:0]  inst_f,
  output logic               valid_d,
  input  logic               ready_d,
  output logic [PC_W-1:0]    pc_d,
  output logic [INST_W-1:0]  inst_d,
  output logic [FWD_W-1:0]   forward_add_d,
  output logic [STALL_W-1:0] stall_cnt
);
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [FWD_W-1:0]  fwd;
  } pay_t;
  localparam pay_t NOP_PAY = '{pc: '0, inst: NOP_INST, fwd: NOP_INST[FWD_LSB +: FWD_W]};
  skid_state_t state, nxt;
  pay_t in_p, main_d, main_q, skid_q;
  logic in_fire, out_fire, clr, main_ld, skid_ld;
  assign in_p = '{pc: pc_f, inst: inst_f, fwd: inst_f[FWD_LSB +: FWD_W]};
  assign in_fire = valid_f & ready_f;
  assign out_fire = valid_d & ready_d;
  assign clr = reset | flush;
  assign main_ld = (state == EMPTY & in_fire) | (state == ONE & in_fire & out_fire) | (state == TWO & out_fire);
  assign skid_ld = state == ONE & in_fire & ~out_fire;
  assign main_d = state == TWO ? skid_q : in_p;
  assign pc_d = main_q.pc;
  assign inst_d = main_q.inst;
  assign forward_add_d = main_q.fwd;
  pipe_payload_reg #(.T(pay_t), .CLR_VAL(NOP_PAY)) u_main (
    .clk(clk), .clr(clr), .ld(main_ld), .d(main_d), .q(main_q)
  );
  pipe_payload_reg #(.T(pay_t), .CLR_VAL(NOP_PAY)) u_skid (
    .clk(clk), .clr(clr), .ld(skid_ld), .d(in_p), .q(skid_q)
  );
  // occupancy state; reset and flush both empty the buffer
  always_ff @(posedge clk)
    if (clr) state <= EMPTY;
    else state <= nxt;
  // occupancy transitions from the two handshakes
  always_comb
    nxt = state == EMPTY ? (in_fire ? ONE : EMPTY) :
          state == ONE   ? (in_fire & ~out_fire ? TWO : ~in_fire & out_fire ? EMPTY : ONE) :
                           (out_fire ? ONE : TWO);
  // handshake outputs decode straight from the state register, no path from ready_d
  always_comb begin
    ready_f = state != TWO;
    valid_d = state != EMPTY;
  end
  // saturating stall counter, survives flush
  always_ff @(posedge clk)
    if (reset) stall_cnt <= '0;
    else if (valid_d & ~ready_d & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
endmodule
